uart_cmd_decoder: RTL and testbench

Parametrised decoder for command bytes received from the opponent board over the UART link. It generates the victory pulse and the opponent-ready level. Beyond those two commands it adds a multi-byte score frame, an inter-byte timeout with a frame-error flag, and an expiry on the opponent-ready level. It sits between the UART receiver and the game-control FSM.

---
 rtl/uart_cmd_decoder_if.sv | 29 ++
 rtl/uart_cmd_decoder.sv | 152 +++++++++++++++
 tb/tb_uart_cmd_decoder.sv | 243 ++++++++++++++++++++++++
 3 files changed

// File: rtl/uart_cmd_decoder_if.sv
// Purpose: bundles the received-character strobe, the play-menu qualifier and the decoded command outputs.
// Latency: none, this is wiring only.
// Backpressure: none; rx_valid is a one-cycle strobe with no ready return path.
// Ports (master = UART/game side, slave = decoder):
//   play_selected, rx_data, rx_valid            -> into the decoder
//   victory, opponent_ready, score, score_valid, frame_err <- out of the decoder
interface uart_cmd_decoder_if #(
    parameter int DATA_W        = 8,
    parameter int PAYLOAD_BYTES = 2
);
    logic                              play_selected;
    logic [DATA_W-1:0]                 rx_data;
    logic                              rx_valid;
    logic                              victory;
    logic                              opponent_ready;
    logic [DATA_W*PAYLOAD_BYTES-1:0]   score;
    logic                              score_valid;
    logic                              frame_err;

    modport master (
        output play_selected, rx_data, rx_valid,
        input  victory, opponent_ready, score, score_valid, frame_err
    );

    modport slave (
        input  play_selected, rx_data, rx_valid,
        output victory, opponent_ready, score, score_valid, frame_err
    );
endinterface

// File: rtl/uart_cmd_decoder.sv
// Purpose: decodes opponent command bytes (victory, ready/heartbeat, multi-byte score frame) from the UART link.
// Latency: one cycle; every output is registered off the edge that samples the rx_valid byte.
// Backpressure: none; every rx_valid strobe is consumed in the cycle it arrives.
// Ports: clk, rst (async active-low) plain; cmd_if (slave) carries the rx strobe, play_selected and all decoded outputs.
module uart_cmd_decoder #(
    parameter int                 DATA_W        = 8,
    parameter logic [DATA_W-1:0]  CHAR_VICTORY  = 8'h4C,
    parameter logic [DATA_W-1:0]  CHAR_READY    = 8'h52,
    parameter logic [DATA_W-1:0]  CHAR_SCORE    = 8'h53,
    parameter int                 PAYLOAD_BYTES = 2,
    parameter int                 BYTE_TIMEOUT  = 1000,
    parameter int                 READY_HOLD    = 50000000
) (
    input  logic               clk,
    input  logic               rst,
    uart_cmd_decoder_if.slave  cmd_if
);
    localparam int SCORE_W = DATA_W * PAYLOAD_BYTES;
    // READY_HOLD=0 disables expiry; keep the counter at least one bit wide so it still elaborates.
    localparam int RDY_W   = (READY_HOLD > 0) ? $clog2(READY_HOLD + 1) : 1;
    localparam int GAP_W   = $clog2(BYTE_TIMEOUT + 1);
    localparam int IDX_W   = $clog2(PAYLOAD_BYTES + 1);

    localparam logic [RDY_W-1:0] RDY_LOAD = RDY_W'(READY_HOLD);
    localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'(BYTE_TIMEOUT - 1);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(PAYLOAD_BYTES - 1);

    typedef enum logic {S_IDLE, S_PAYLOAD} state_t;

    state_t               r_state,   w_state_nxt;
    logic [IDX_W-1:0]     r_idx,     w_idx_nxt;
    logic [GAP_W-1:0]     r_gap,     w_gap_nxt;
    logic [SCORE_W-1:0]   r_shift,   w_shift_nxt;
    logic [SCORE_W-1:0]   r_score,   w_score_nxt;
    logic [RDY_W-1:0]     r_rdy_cnt, w_rdy_cnt_nxt;
    logic                 r_ready,   w_ready_nxt;
    logic                 r_victory, w_victory_nxt;
    logic                 r_score_vld, w_score_vld_nxt;
    logic                 r_frame_err, w_frame_err_nxt;
    logic                 w_rdy_load;
    logic [SCORE_W-1:0]   w_assembled;

    // Bytes already in the assembly register move up one slot; the oldest ends up as the MSB.
    assign w_assembled = (r_shift << DATA_W) | SCORE_W'(cmd_if.rx_data);

    // Decode FSM: next state, frame assembly and the one-cycle pulses.
    always_comb begin
        w_state_nxt     = r_state;
        w_idx_nxt       = r_idx;
        w_gap_nxt       = r_gap;
        w_shift_nxt     = r_shift;
        w_score_nxt     = r_score;
        w_victory_nxt   = 1'b0;
        w_score_vld_nxt = 1'b0;
        w_frame_err_nxt = 1'b0;
        w_rdy_load      = 1'b0;

        case (r_state)
            S_IDLE: begin
                if (cmd_if.rx_valid) begin
                    if (cmd_if.rx_data == CHAR_VICTORY) begin
                        w_victory_nxt = 1'b1;
                    end else if (cmd_if.rx_data == CHAR_READY) begin
                        w_rdy_load = cmd_if.play_selected;
                    end else if (cmd_if.rx_data == CHAR_SCORE) begin
                        w_state_nxt = S_PAYLOAD;
                        w_idx_nxt   = '0;
                        w_gap_nxt   = '0;
                    end
                end
            end
            S_PAYLOAD: begin
                // Inside a frame every byte is data, even if it matches an opcode.
                if (cmd_if.rx_valid) begin
                    w_shift_nxt = w_assembled;
                    w_gap_nxt   = '0;
                    if (r_idx == IDX_LAST) begin
                        w_score_nxt     = w_assembled;
                        w_score_vld_nxt = 1'b1;
                        w_idx_nxt       = '0;
                        w_state_nxt     = S_IDLE;
                    end else begin
                        w_idx_nxt = r_idx + 1'b1;
                    end
                end else if (r_gap + 1'b1 == GAP_LAST) begin
                    // Partial frame is dropped; score keeps its last complete value.
                    w_frame_err_nxt = 1'b1;
                    w_gap_nxt       = '0;
                    w_idx_nxt       = '0;
                    w_state_nxt     = S_IDLE;
                end else begin
                    w_gap_nxt = r_gap + 1'b1;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // Opponent-ready level: leaving the play menu wins over a reload, a reload wins over victory/expiry.
    always_comb begin
        w_ready_nxt   = r_ready;
        w_rdy_cnt_nxt = r_rdy_cnt;
        if (!cmd_if.play_selected) begin
            w_ready_nxt   = 1'b0;
            w_rdy_cnt_nxt = '0;
        end else if (w_rdy_load) begin
            w_ready_nxt   = 1'b1;
            w_rdy_cnt_nxt = RDY_LOAD;
        end else if (w_victory_nxt) begin
            w_ready_nxt   = 1'b0;
            w_rdy_cnt_nxt = '0;
        end else if (r_ready && (READY_HOLD != 0)) begin
            // Dropping as the count goes 1->0 keeps the level high for exactly READY_HOLD cycles.
            w_rdy_cnt_nxt = r_rdy_cnt - 1'b1;
            if (r_rdy_cnt == RDY_W'(1)) begin
                w_ready_nxt = 1'b0;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state     <= S_IDLE;
            r_idx       <= '0;
            r_gap       <= '0;
            r_shift     <= '0;
            r_score     <= '0;
            r_rdy_cnt   <= '0;
            r_ready     <= 1'b0;
            r_victory   <= 1'b0;
            r_score_vld <= 1'b0;
            r_frame_err <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_idx       <= w_idx_nxt;
            r_gap       <= w_gap_nxt;
            r_shift     <= w_shift_nxt;
            r_score     <= w_score_nxt;
            r_rdy_cnt   <= w_rdy_cnt_nxt;
            r_ready     <= w_ready_nxt;
            r_victory   <= w_victory_nxt;
            r_score_vld <= w_score_vld_nxt;
            r_frame_err <= w_frame_err_nxt;
        end
    end

    assign cmd_if.victory        = r_victory;
    assign cmd_if.opponent_ready = r_ready;
    assign cmd_if.score          = r_score;
    assign cmd_if.score_valid    = r_score_vld;
    assign cmd_if.frame_err      = r_frame_err;
endmodule

// File: tb/tb_uart_cmd_decoder.sv
// Purpose: self-checking bench for uart_cmd_decoder: directed scenarios plus randomized traffic against a timestamp/queue model.
// Latency: model expects outputs one edge after the sampling edge.
// Backpressure: none exercised; the decoder never stalls the strobe.
module tb_uart_cmd_decoder;
    localparam int          DW  = 8;
    localparam int          PB  = 2;
    localparam int          BT  = 8;
    localparam int          RH  = 16;
    localparam int          SW  = DW * PB;
    localparam logic [7:0]  OP_VIC = 8'h4C;
    localparam logic [7:0]  OP_RDY = 8'h52;
    localparam logic [7:0]  OP_SCR = 8'h53;

    logic clk;
    logic rst_n;
    int   n_chk;
    int   n_pass;

    uart_cmd_decoder_if #(.DATA_W(DW), .PAYLOAD_BYTES(PB)) ifc ();

    uart_cmd_decoder #(
        .DATA_W(DW), .CHAR_VICTORY(OP_VIC), .CHAR_READY(OP_RDY), .CHAR_SCORE(OP_SCR),
        .PAYLOAD_BYTES(PB), .BYTE_TIMEOUT(BT), .READY_HOLD(RH)
    ) dut (
        .clk(clk),
        .rst(rst_n),
        .cmd_if(ifc.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h, expected %h at %0t", nm, act, exp, $time);
    endtask

    // ---------------- behavioural model ----------------
    // Frame held as a byte queue; timeouts and ready expiry kept as edge timestamps.
    int          m_edge;
    bit          m_in_frame;
    logic [7:0]  m_fq[$];
    int          m_last;
    int          m_ready_end;
    logic        e_vic, e_rdy, e_sv, e_fe;
    logic [SW-1:0] e_score;

    task automatic m_reset();
        m_in_frame  = 1'b0;
        m_fq.delete();
        m_last      = 0;
        m_ready_end = m_edge;
        e_vic = 1'b0; e_rdy = 1'b0; e_sv = 1'b0; e_fe = 1'b0;
        e_score = '0;
    endtask

    // Predict the outputs after the coming posedge from the inputs currently applied.
    task automatic m_step(input logic v, input logic [7:0] d, input logic ps);
        bit vic;
        bit rdy_cmd;
        logic [SW-1:0] acc;
        vic = 1'b0; rdy_cmd = 1'b0;
        e_sv = 1'b0; e_fe = 1'b0;
        if (m_in_frame) begin
            if (v) begin
                m_fq.push_back(d);
                m_last = m_edge;
                if (m_fq.size() == PB) begin
                    acc = '0;
                    foreach (m_fq[i]) acc = (acc << 8) | SW'(m_fq[i]);
                    e_score = acc;
                    e_sv = 1'b1;
                    m_in_frame = 1'b0;
                    m_fq.delete();
                end
            end else if (m_edge - m_last >= BT - 1) begin
                e_fe = 1'b1;
                m_in_frame = 1'b0;
                m_fq.delete();
            end
        end else if (v) begin
            if (d == OP_VIC) vic = 1'b1;
            else if (d == OP_RDY) rdy_cmd = ps;
            else if (d == OP_SCR) begin
                m_in_frame = 1'b1;
                m_fq.delete();
                m_last = m_edge;
            end
        end
        if (!ps)          m_ready_end = m_edge;
        else if (rdy_cmd) m_ready_end = (RH == 0) ? 32'h7fff_ffff : m_edge + RH;
        else if (vic)     m_ready_end = m_edge;
        e_vic  = vic;
        e_rdy  = (m_edge < m_ready_end);
        m_edge++;
    endtask

    // Compare process: outputs are stable at the falling edge; inputs change only just after rising edges.
    always @(negedge clk) begin
        if (!rst_n) m_reset();
        chk("victory",        32'(ifc.victory),        32'(e_vic));
        chk("opponent_ready", 32'(ifc.opponent_ready), 32'(e_rdy));
        chk("score",          32'(ifc.score),          32'(e_score));
        chk("score_valid",    32'(ifc.score_valid),    32'(e_sv));
        chk("frame_err",      32'(ifc.frame_err),      32'(e_fe));
        if (rst_n) m_step(ifc.rx_valid, ifc.rx_data, ifc.play_selected);
    end

    // ---------------- stimulus helpers ----------------
    // Caller is always parked 1 time unit after a rising edge.
    task automatic send(input logic [7:0] d);
        ifc.rx_valid = 1'b1;
        ifc.rx_data  = d;
        @(posedge clk); #1;
        ifc.rx_valid = 1'b0;
        ifc.rx_data  = 8'($urandom);
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk); #1;
        end
    endtask

    initial begin
        n_chk = 0; n_pass = 0; m_edge = 0;
        m_reset();
        rst_n = 1'b0;
        ifc.play_selected = 1'b1;
        ifc.rx_valid = 1'b0;
        ifc.rx_data  = 8'h00;
        @(posedge clk); #1;
        chk("reset_victory", 32'(ifc.victory), 32'd0);
        chk("reset_ready",   32'(ifc.opponent_ready), 32'd0);
        chk("reset_score",   32'(ifc.score), 32'd0);
        idle(1);
        rst_n = 1'b1;
        idle(2);

        // Victory pulse, exactly one cycle.
        send(OP_VIC);
        chk("vic_pulse", 32'(ifc.victory), 32'd1);
        idle(1);
        chk("vic_gone", 32'(ifc.victory), 32'd0);

        // Ready level holds RH cycles.
        send(OP_RDY);
        chk("rdy_rise", 32'(ifc.opponent_ready), 32'd1);
        idle(RH - 1);
        chk("rdy_last_hi", 32'(ifc.opponent_ready), 32'd1);
        idle(1);
        chk("rdy_expired", 32'(ifc.opponent_ready), 32'd0);

        // Reload at +10 pushes expiry to +26.
        send(OP_RDY);
        idle(9);
        send(OP_RDY);
        idle(15);
        chk("rdy_ext_hi", 32'(ifc.opponent_ready), 32'd1);
        idle(1);
        chk("rdy_ext_lo", 32'(ifc.opponent_ready), 32'd0);

        // play_selected low beats a simultaneous ready byte.
        send(OP_RDY);
        ifc.play_selected = 1'b0;
        send(OP_RDY);
        chk("rdy_prio_clr", 32'(ifc.opponent_ready), 32'd0);
        send(OP_RDY);
        chk("rdy_not_sel", 32'(ifc.opponent_ready), 32'd0);
        ifc.play_selected = 1'b1;
        idle(1);

        // Score frame with an opcode-valued payload byte.
        send(OP_SCR); idle(3);
        send(8'h4C);
        chk("frame_no_vic", 32'(ifc.victory), 32'd0);
        idle(3);
        send(8'h12);
        chk("score_val", 32'(ifc.score), 32'h4C12);
        chk("score_pulse", 32'(ifc.score_valid), 32'd1);
        idle(1);
        chk("score_pulse_end", 32'(ifc.score_valid), 32'd0);

        // Timeout after one payload byte.
        send(OP_SCR);
        send(8'hAB);
        idle(BT - 2);
        chk("fe_early", 32'(ifc.frame_err), 32'd0);
        idle(1);
        chk("fe_pulse", 32'(ifc.frame_err), 32'd1);
        chk("fe_score_kept", 32'(ifc.score), 32'h4C12);
        idle(1);
        chk("fe_pulse_end", 32'(ifc.frame_err), 32'd0);
        send(OP_VIC);
        chk("fe_then_vic", 32'(ifc.victory), 32'd1);

        // Asynchronous reset mid-frame.
        send(OP_RDY);
        send(OP_SCR);
        send(8'hAB);
        #2 rst_n = 1'b0;
        #1;
        chk("arst_ready", 32'(ifc.opponent_ready), 32'd0);
        chk("arst_score", 32'(ifc.score), 32'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        send(8'hCD);
        chk("post_rst_sv1", 32'(ifc.score_valid), 32'd0);
        send(8'hEF);
        chk("post_rst_sv2", 32'(ifc.score_valid), 32'd0);
        chk("post_rst_score", 32'(ifc.score), 32'd0);
        idle(2);

        // Randomized traffic; density changes in phases so timeouts and full frames both occur.
        begin
            int dens;
            dens = 30;
            for (int c = 0; c < 4000; c++) begin
                if (c % 250 == 0) dens = $urandom_range(5, 70);
                if (ifc.play_selected) begin
                    if ($urandom_range(0, 99) == 0) ifc.play_selected = 1'b0;
                end else if ($urandom_range(0, 9) == 0) begin
                    ifc.play_selected = 1'b1;
                end
                rst_n = ($urandom_range(0, 699) != 0);
                ifc.rx_valid = ($urandom_range(0, 99) < dens);
                case ($urandom_range(0, 3))
                    0: ifc.rx_data = OP_VIC;
                    1: ifc.rx_data = OP_RDY;
                    2: ifc.rx_data = OP_SCR;
                    default: ifc.rx_data = 8'($urandom);
                endcase
                @(posedge clk); #1;
            end
        end
        rst_n = 1'b1;
        ifc.rx_valid = 1'b0;
        idle(4);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
